// File: rtl/shifter_pkg.sv
// shifter_pkg: op encodings and level-count helper shared by the pipelined barrel shifter.
package shifter_pkg;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic int levels_of(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one mux level (shift by 2^K) plus its pipeline register.
// ROR wrap legs exist only when PIPELINED_SHIFTER_ROTATE_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int K      = 0,
    parameter int LEVELS = levels_of(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_adv,
    input  logic              i_valid,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [1:0]        i_op,
    input  logic [LEVELS-1:0] i_shamt,
    input  logic              i_fill,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    output logic [1:0]        o_op,
    output logic [LEVELS-1:0] o_shamt,
    output logic              o_fill
);
    localparam int S = 1 << K;

    logic [WIDTH-1:0] w_right;
    logic [WIDTH-1:0] w_shifted;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [1:0]       r_op;
    logic [LEVELS-1:0] r_shamt;
    logic             r_fill;

`ifdef PIPELINED_SHIFTER_ROTATE_EN
    assign w_right = (i_op == OP_ROR) ? ((i_data >> S) | (i_data << (WIDTH - S)))
                                      : ((i_data >> S) | ({WIDTH{i_fill}} << (WIDTH - S)));
`else
    // fill is 0 for everything but SRA, so op 11 degenerates to SRL
    assign w_right = (i_data >> S) | ({WIDTH{i_fill}} << (WIDTH - S));
`endif

    assign w_shifted = !i_shamt[K]        ? i_data :
                       (i_op == OP_SLL)   ? (i_data << S) : w_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_op    <= '0;
            r_shamt <= '0;
            r_fill  <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_data  <= w_shifted;
            r_op    <= i_op;
            r_shamt <= i_shamt;
            r_fill  <= i_fill;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_op    = r_op;
    assign o_shamt = r_shamt;
    assign o_fill  = r_fill;
endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: LEVELS-stage barrel shifter (SLL/SRL/SRA, ROR under
// PIPELINED_SHIFTER_ROTATE_EN) with a single global advance for backpressure.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LEVELS = levels_of(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [LEVELS-1:0] in_shamt,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_zero
);
    logic              w_adv;
    logic              w_valid [0:LEVELS];
    logic [WIDTH-1:0]  w_data  [0:LEVELS];
    logic [1:0]        w_op    [0:LEVELS];
    logic [LEVELS-1:0] w_shamt [0:LEVELS];
    logic              w_fill  [0:LEVELS];
    logic              w_unused;

    // whole pipe moves or whole pipe holds; bubbles are not squeezed out
    assign w_adv      = out_ready || !out_valid;
    assign in_ready   = w_adv;
    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_op[0]    = in_op;
    assign w_shamt[0] = in_shamt;
    assign w_fill[0]  = (in_op == OP_SRA) && in_data[WIDTH-1];

    for (genvar g = 0; g < LEVELS; g++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .K(g), .LEVELS(LEVELS)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_adv  (w_adv),
            .i_valid(w_valid[g]),
            .i_data (w_data[g]),
            .i_op   (w_op[g]),
            .i_shamt(w_shamt[g]),
            .i_fill (w_fill[g]),
            .o_valid(w_valid[g+1]),
            .o_data (w_data[g+1]),
            .o_op   (w_op[g+1]),
            .o_shamt(w_shamt[g+1]),
            .o_fill (w_fill[g+1])
        );
    end

    assign w_unused  = ^{w_op[LEVELS], w_shamt[LEVELS], w_fill[LEVELS]};
    assign out_valid = w_valid[LEVELS];
    assign out_data  = w_data[LEVELS];
    assign out_zero  = ~|out_data;
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed table, stream/stall/reset sequences and random traffic
// against a queue scoreboard; honours PIPELINED_SHIFTER_ROTATE_EN.
module tb_pipelined_shifter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    pipelined_shifter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        logic [63:0] w;
        w = {d, d} >> s;
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            default: return w[31:0];
`else
            default: return d >> s;
`endif
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: transfers are decided by values stable across the negedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_unexpected_output", 32'd1, 32'd0);
                else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    check("sb_data", out_data, e);
                    check("sb_zero", {31'd0, out_zero}, {31'd0, e == 32'd0});
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(in_data, in_shamt, in_op));
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic apply_one(input vec_t v, input int idx);
        int lat;
        lat = 0;
        in_data = v.data; in_shamt = v.shamt; in_op = v.op; in_valid = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check($sformatf("vec%0d_latency", idx), lat, 32'd5);
        check($sformatf("vec%0d_data", idx), out_data, v.exp);
        check($sformatf("vec%0d_zero", idx), {31'd0, out_zero}, {31'd0, v.exp == 32'd0});
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        in_data = d; in_shamt = s; in_op = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(posedge clk);
        #1;
        check(name, sb_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_s[5];
        logic [31:0] held;
        int cnt;
        logic [31:0] seen;
        vecs[0]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
        vecs[1]  = '{32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F};
        vecs[2]  = '{32'h8000_00F0, 5'd4,  2'b01, 32'h0800_000F};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF};
        vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF};
        vecs[6]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
        vecs[7]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
        vecs[8]  = '{32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000};
        vecs[10] = '{32'h7FFF_FFFF, 5'd1,  2'b10, 32'h3FFF_FFFF};
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        vecs[3]  = '{32'h0000_00FF, 5'd8,  2'b11, 32'hFF00_0000};
        vecs[9]  = '{32'h1234_5678, 5'd16, 2'b11, 32'h5678_1234};
        vecs[11] = '{32'h0000_0003, 5'd1,  2'b11, 32'h8000_0001};
`else
        vecs[3]  = '{32'h0000_00FF, 5'd8,  2'b11, 32'h0000_0000};
        vecs[9]  = '{32'h1234_5678, 5'd16, 2'b11, 32'h0000_1234};
        vecs[11] = '{32'h0000_0003, 5'd1,  2'b11, 32'h0000_0001};
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_zero", {31'd0, out_zero}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) apply_one(vecs[i], i);

        // streaming: five back-to-back, results on consecutive cycles
        for (int i = 0; i < 5; i++) begin
            exp_s[i] = model(32'h1111_1111 * (i + 1), 5'(i * 3), 2'(i % 3));
            send(32'h1111_1111 * (i + 1), 5'(i * 3), 2'(i % 3));
            in_valid = (i < 4);
        end
        wait_out("stream");
        check("stream_r0", out_data, exp_s[0]);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stream_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream_r%0d", i), out_data, exp_s[i]);
        end
        drain("stream_drain");

        // stall with a full pipe
        for (int i = 0; i < 5; i++) begin
            send(32'hC0DE_0000 + i, 5'(7 + i), 2'(3 - (i % 4)));
            in_valid = (i < 4);
        end
        wait_out("stall");
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_data = 32'hBAD0_BAD0; in_shamt = 5'd1; in_op = 2'b00; in_valid = 1'b1;
        @(negedge clk);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("stall_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("stall_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall_data%0d", i), out_data, held);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("stall_drain");

        // reset with three operands in flight behind a stalled output
        out_ready = 1'b0;
        send(32'h1357_9BDF, 5'd3, 2'b00);
        send(32'h2468_ACE0, 5'd5, 2'b01);
        send(32'hF000_0001, 5'd2, 2'b10);
        wait_out("prereset");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_zero", {31'd0, out_zero}, 32'd1);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        send(32'hA5A5_5A5A, 5'd0, 2'b10);
        cnt = 0; seen = '0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                seen = out_data;
            end
        end
        check("postrst_count", cnt, 32'd1);
        check("postrst_data", seen, 32'hA5A5_5A5A);

        // random traffic with random backpressure
        @(posedge clk); #1;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_op     = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
